// File: rtl/cache_mem_arbiter_pkg.sv
// cache_pkg: shared definitions for the cache/memory arbiter.
//   - Layout of the 33-bit memory request {rw, data[15:0], addr[15:0]}
//   - Read/write encodings of the rw bit
//   - Arbiter state encodings
package cache_pkg;

    localparam int REQ_W        = 33;
    localparam int REQ_RW       = 32;
    localparam int REQ_DATA_MSB = 31;
    localparam int REQ_DATA_LSB = 16;
    localparam int REQ_ADDR_MSB = 15;
    localparam int REQ_ADDR_LSB = 0;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ISSUE    = 2'b01,
        ST_WAIT_MEM = 2'b10,
        ST_RELEASE  = 2'b11
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req  : request vector, one bit per requester
//   ptr  : index where the scan starts (highest priority)
//   any  : at least one request is set
//   idx  : first set bit scanning ptr, ptr+1, ... modulo N
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic         any,
    output logic [2:0]   idx
);

    // Two passes: first the bits at or above ptr, then wrap to the bottom.
    // The second pass only matters when nothing at or above ptr is set.
    always_comb begin
        any = 1'b0;
        idx = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any = 1'b1;
                idx = 3'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any = 1'b1;
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one main-memory port between NUM_CACHES caches
// with round-robin arbitration, routes the response back to the owner and
// broadcasts an invalidate to the other caches on every write.
//
// Ports:
//   clock, reset (async, active low)
//   cache_req / cache_req_ready      : per-cache 33-bit request and request level
//   cache_resp / cache_resp_ready    : response data (broadcast) and one-hot strobe
//   inv_addr / inv_valid             : invalidate address and per-cache strobe
//   mem_req / mem_req_valid          : request to memory and one-cycle issue strobe
//   mem_resp / mem_resp_valid        : memory read data and completion strobe
//   grant, busy                      : current owner index, non-idle flag
//   timeout_err                      : sticky watchdog flag (ARB_TIMEOUT_EN only)
//
// Build option: define ARB_TIMEOUT_EN to add a memory watchdog that answers
// 16'hDEAD after TIMEOUT_CYCLES cycles without a memory response.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for a request; round-robin pick and latch
// ST_ISSUE    | drive the latched request to memory with a strobe
// ST_WAIT_MEM | wait for mem_resp_valid (or watchdog expiry)
// ST_RELEASE  | one-cycle gap; advance rr_ptr past the owner
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_CACHES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [REQ_W*NUM_CACHES-1:0] cache_req,
    input  logic [NUM_CACHES-1:0]       cache_req_ready,
    output logic [15:0]                 cache_resp,
    output logic [NUM_CACHES-1:0]       cache_resp_ready,
    output logic [15:0]                 inv_addr,
    output logic [NUM_CACHES-1:0]       inv_valid,
    output logic [REQ_W-1:0]            mem_req,
    output logic                        mem_req_valid,
    input  logic [15:0]                 mem_resp,
    input  logic                        mem_resp_valid,
    output logic [2:0]                  grant,
`ifdef ARB_TIMEOUT_EN
    output logic                        busy,
    output logic                        timeout_err
`else
    output logic                        busy
`endif
);

    if (NUM_CACHES < 2 || NUM_CACHES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("cache_mem_arbiter: NUM_CACHES or TIMEOUT_CYCLES out of range");
    end

    arb_state_t              state_q, state_d;
    logic [2:0]              rr_ptr_q, rr_ptr_d;
    logic [2:0]              grant_q, grant_d;
    logic [REQ_W-1:0]        req_q, req_d;
    logic [15:0]             cache_resp_q, cache_resp_d;
    logic [NUM_CACHES-1:0]   cache_resp_ready_q, cache_resp_ready_d;
    logic [15:0]             inv_addr_q, inv_addr_d;
    logic [NUM_CACHES-1:0]   inv_valid_q, inv_valid_d;
    logic [REQ_W-1:0]        mem_req_q, mem_req_d;
    logic                    mem_req_valid_q, mem_req_valid_d;
`ifdef ARB_TIMEOUT_EN
    logic [15:0]             tmo_cnt_q, tmo_cnt_d;
    logic                    timeout_err_q, timeout_err_d;
`endif

    logic                    pick_any;
    logic [2:0]              pick_idx;
    logic [REQ_W-1:0]        pick_req;
    logic [NUM_CACHES-1:0]   grant_onehot;

    rr_picker #(.N(NUM_CACHES)) u_rr_picker (
        .req (cache_req_ready),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Mux over constant slices keeps the select width-clean for any NUM_CACHES.
    always_comb begin
        pick_req = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (pick_idx == 3'(i)) begin
                pick_req = cache_req[i*REQ_W +: REQ_W];
            end
        end
    end

    assign grant_onehot = NUM_CACHES'(1) << grant_q;

    always_comb begin
        state_d            = state_q;
        rr_ptr_d           = rr_ptr_q;
        grant_d            = grant_q;
        req_d              = req_q;
        cache_resp_d       = cache_resp_q;
        cache_resp_ready_d = '0;
        inv_addr_d         = inv_addr_q;
        inv_valid_d        = '0;
        mem_req_d          = mem_req_q;
        mem_req_valid_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d          = tmo_cnt_q;
        timeout_err_d      = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    req_d   = pick_req;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_d       = req_q;
                mem_req_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                tmo_cnt_d       = 16'd0;
`endif
                state_d         = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (mem_resp_valid) begin
                    // Writes echo their own data back as the acknowledge value.
                    cache_resp_d       = (req_q[REQ_RW] == READ) ? mem_resp
                                                                 : req_q[REQ_DATA_MSB:REQ_DATA_LSB];
                    cache_resp_ready_d = grant_onehot;
                    if (req_q[REQ_RW] == WRITE) begin
                        inv_addr_d  = req_q[REQ_ADDR_MSB:REQ_ADDR_LSB];
                        inv_valid_d = ~grant_onehot;
                    end
                    state_d = ST_RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES)) begin
                    cache_resp_d       = 16'hDEAD;
                    cache_resp_ready_d = grant_onehot;
                    timeout_err_d      = 1'b1;
                    state_d            = ST_RELEASE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            ST_RELEASE: begin
                rr_ptr_d = (grant_q == 3'(NUM_CACHES-1)) ? 3'd0 : grant_q + 3'd1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q            <= ST_IDLE;
            rr_ptr_q           <= 3'd0;
            grant_q            <= 3'd0;
            req_q              <= '0;
            cache_resp_q       <= 16'd0;
            cache_resp_ready_q <= '0;
            inv_addr_q         <= 16'd0;
            inv_valid_q        <= '0;
            mem_req_q          <= '0;
            mem_req_valid_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q          <= 16'd0;
            timeout_err_q      <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            rr_ptr_q           <= rr_ptr_d;
            grant_q            <= grant_d;
            req_q              <= req_d;
            cache_resp_q       <= cache_resp_d;
            cache_resp_ready_q <= cache_resp_ready_d;
            inv_addr_q         <= inv_addr_d;
            inv_valid_q        <= inv_valid_d;
            mem_req_q          <= mem_req_d;
            mem_req_valid_q    <= mem_req_valid_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q          <= tmo_cnt_d;
            timeout_err_q      <= timeout_err_d;
`endif
        end
    end

    assign cache_resp       = cache_resp_q;
    assign cache_resp_ready = cache_resp_ready_q;
    assign inv_addr         = inv_addr_q;
    assign inv_valid        = inv_valid_q;
    assign mem_req          = mem_req_q;
    assign mem_req_valid    = mem_req_valid_q;
    assign grant            = grant_q;
    assign busy             = (state_q != ST_IDLE);
`ifdef ARB_TIMEOUT_EN
    assign timeout_err      = timeout_err_q;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter with two caches. Expected memory requests
// and cache responses are queued when stimulus is applied and compared when
// the arbiter issues / strobes.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    localparam int N = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic                 clock;
    logic                 reset;
    logic [REQ_W*N-1:0]   cache_req;
    logic [N-1:0]         cache_req_ready;
    logic [15:0]          cache_resp;
    logic [N-1:0]         cache_resp_ready;
    logic [15:0]          inv_addr;
    logic [N-1:0]         inv_valid;
    logic [REQ_W-1:0]     mem_req;
    logic                 mem_req_valid;
    logic [15:0]          mem_resp;
    logic                 mem_resp_valid;
    logic [2:0]           grant;
    logic                 busy;
`ifdef ARB_TIMEOUT_EN
    logic                 timeout_err;
`endif

    cache_mem_arbiter #(.NUM_CACHES(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clock            (clock),
        .reset            (reset),
        .cache_req        (cache_req),
        .cache_req_ready  (cache_req_ready),
        .cache_resp       (cache_resp),
        .cache_resp_ready (cache_resp_ready),
        .inv_addr         (inv_addr),
        .inv_valid        (inv_valid),
        .mem_req          (mem_req),
        .mem_req_valid    (mem_req_valid),
        .mem_resp         (mem_resp),
        .mem_resp_valid   (mem_resp_valid),
        .grant            (grant),
`ifdef ARB_TIMEOUT_EN
        .busy             (busy),
        .timeout_err      (timeout_err)
`else
        .busy             (busy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] rdy;
        logic [15:0]  data;
        logic [15:0]  iaddr;
        logic [N-1:0] ival;
        logic [2:0]   gnt;
    } exp_t;

    exp_t         exp_resp[$];
    logic [32:0]  exp_mem[$];

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   issue_cyc  = 0;
    int   resp_cyc   = 0;
    int   mrv_cyc    = 0;
    bit   prev_mrv   = 0;
    bit   auto_drop  = 1;
    bit   mem_enable = 1;
    bit   mem_pend   = 0;
    int   mem_cnt    = 0;
    int   mem_lat    = 2;
    logic mem_rw     = 1'b0;
    logic [15:0] mem_rd_data = 16'h0;

    // Advance one clock, sample outputs 1ns after the edge, then update the memory model.
    task automatic tick();
        exp_t        e;
        logic [32:0] m;
        @(posedge clock);
        #1;
        cyc++;
        if (mem_req_valid) begin
            compared++;
            if (prev_mrv !== 1'b0) begin
                mismatched++;
                $display("FAIL mem_req_valid_width: valid high on consecutive cycles, required one-cycle strobe");
            end
            compared++;
            if (exp_mem.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_issue: mem_req=%h issued with no request expected", mem_req);
            end else begin
                m = exp_mem.pop_front();
                if (mem_req !== m) begin
                    mismatched++;
                    $display("FAIL mem_req: got %h required %h", mem_req, m);
                end
            end
            issue_cyc = cyc;
            if (mem_enable) begin
                mem_pend = 1;
                mem_cnt  = mem_lat;
                mem_rw   = mem_req[32];
            end
        end
        prev_mrv = mem_req_valid;
        if (cache_resp_ready !== '0 || inv_valid !== '0) begin
            compared++;
            if (exp_resp.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_strobe: cache_resp_ready=%b inv_valid=%b with nothing expected",
                         cache_resp_ready, inv_valid);
            end else begin
                e = exp_resp.pop_front();
                if (cache_resp_ready !== e.rdy || cache_resp !== e.data || inv_valid !== e.ival ||
                    grant !== e.gnt || (e.ival != '0 && inv_addr !== e.iaddr)) begin
                    mismatched++;
                    $display("FAIL response: got rdy=%b data=%h ival=%b iaddr=%h gnt=%0d required rdy=%b data=%h ival=%b iaddr=%h gnt=%0d",
                             cache_resp_ready, cache_resp, inv_valid, inv_addr, grant,
                             e.rdy, e.data, e.ival, e.iaddr, e.gnt);
                end
            end
            resp_cyc = cyc;
            if (auto_drop) cache_req_ready = cache_req_ready & ~cache_resp_ready;
        end
        mem_resp_valid = 1'b0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp       = mem_rw ? 16'h7777 : mem_rd_data;
                mem_pend       = 0;
                mrv_cyc        = cyc;
            end else begin
                mem_cnt--;
            end
        end
    endtask

    task automatic expect_txn(input int c, input logic [32:0] rq, input logic [15:0] resp);
        exp_t e;
        exp_mem.push_back(rq);
        e.rdy   = N'(1) << c;
        e.data  = resp;
        e.iaddr = rq[15:0];
        e.ival  = rq[32] ? ~e.rdy : '0;
        e.gnt   = 3'(c);
        exp_resp.push_back(e);
    endtask

    task automatic wait_issue(input string name, input int max);
        int n = 0;
        while (exp_mem.size() != 0 && n < max) begin
            tick();
            n++;
        end
        compared++;
        if (exp_mem.size() != 0) begin
            mismatched++;
            $display("FAIL %s issue: %0d requests not issued after %0d cycles, required 0", name, exp_mem.size(), n);
            exp_mem.delete();
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (exp_resp.size() != 0 && n < max) begin
            tick();
            n++;
        end
        compared++;
        if (exp_resp.size() != 0) begin
            mismatched++;
            $display("FAIL %s drain: %0d responses outstanding after %0d cycles, required 0", name, exp_resp.size(), n);
            exp_resp.delete();
            exp_mem.delete();
        end
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        cache_req_ready = '0;
        mem_resp_valid  = 1'b0;
        mem_pend        = 0;
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b1;
        prev_mrv = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        compared++;
        if ({cache_resp_ready, inv_valid, mem_req_valid, busy} !== '0) begin
            mismatched++;
            $display("FAIL reset_strobes: got rdy=%b ival=%b mrv=%b busy=%b required all 0",
                     cache_resp_ready, inv_valid, mem_req_valid, busy);
        end
        compared++;
        if (mem_req !== '0 || grant !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_req_grant: got mem_req=%h grant=%0d required 0", mem_req, grant);
        end
        compared++;
        if (cache_resp !== 16'h0 || inv_addr !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_data: got cache_resp=%h inv_addr=%h required 0", cache_resp, inv_addr);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_read();
        int start;
        logic [32:0] rq;
        rq = {READ, 16'h0000, 16'h1234};
        mem_rd_data = 16'hABCD;
        cache_req[0 +: 33] = rq;
        expect_txn(0, rq, 16'hABCD);
        start = cyc;
        cache_req_ready = 2'b01;
        wait_issue("read", 10);
        compared++;
        if (issue_cyc - start !== 2) begin
            mismatched++;
            $display("FAIL read_issue_latency: got %0d cycles required 2", issue_cyc - start);
        end
        wait_drain("read", 20);
        compared++;
        if (resp_cyc - mrv_cyc !== 1) begin
            mismatched++;
            $display("FAIL read_resp_latency: got %0d cycles required 1", resp_cyc - mrv_cyc);
        end
        repeat (3) tick();
        compared++;
        if (cache_resp !== 16'hABCD) begin
            mismatched++;
            $display("FAIL read_resp_hold: got %h required abcd", cache_resp);
        end
    endtask

    task automatic test_write();
        logic [32:0] rq;
        rq = {WRITE, 16'h5A5A, 16'h0042};
        cache_req[33 +: 33] = rq;
        expect_txn(1, rq, 16'h5A5A);
        cache_req_ready = 2'b10;
        wait_issue("write", 10);
        // Requester withdraws and changes its request; the transaction must complete as latched.
        cache_req_ready = 2'b00;
        cache_req[33 +: 33] = {WRITE, 16'hFFFF, 16'hFFFF};
        wait_drain("write", 20);
        compared++;
        if (inv_addr !== 16'h0042) begin
            mismatched++;
            $display("FAIL write_inv_addr_hold: got %h required 0042", inv_addr);
        end
    endtask

    task automatic test_stray_resp();
        repeat (2) tick();
        mem_resp       = 16'h1111;
        mem_resp_valid = 1'b1;
        repeat (3) tick();
        compared++;
        if (grant !== 3'd1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL stray_state: got grant=%0d busy=%b required grant=1 busy=0", grant, busy);
        end
        compared++;
        if (cache_resp !== 16'h5A5A) begin
            mismatched++;
            $display("FAIL stray_resp_hold: got %h required 5a5a", cache_resp);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] rd, wr;
        int n = 0;
        do_reset();
        auto_drop   = 0;
        mem_rd_data = 16'hC0DE;
        rd = {READ,  16'h0000, 16'h0100};
        wr = {WRITE, 16'hBEEF, 16'h0200};
        cache_req = {wr, rd};
        for (int i = 0; i < 6; i++) begin
            expect_txn(i % 2, (i % 2 == 1) ? wr : rd, (i % 2 == 1) ? 16'hBEEF : 16'hC0DE);
        end
        cache_req_ready = 2'b11;
        while (exp_resp.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        cache_req_ready = 2'b00;
        compared++;
        if (exp_resp.size() != 0) begin
            mismatched++;
            $display("FAIL rotation_drain: %0d grants outstanding, required 0", exp_resp.size());
            exp_resp.delete();
            exp_mem.delete();
        end
        repeat (6) tick();
        auto_drop = 1;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        mem_enable = 0;
        cache_req[0 +: 33] = {READ, 16'h0000, 16'h0777};
        exp_mem.push_back({READ, 16'h0000, 16'h0777});
        cache_req_ready = 2'b01;
        wait_issue("midflight", 10);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        compared++;
        if ({cache_resp_ready, inv_valid, mem_req_valid, busy, grant} !== '0) begin
            mismatched++;
            $display("FAIL midflight_strobes: got rdy=%b ival=%b mrv=%b busy=%b grant=%0d required all 0",
                     cache_resp_ready, inv_valid, mem_req_valid, busy, grant);
        end
        compared++;
        if (mem_req !== '0 || cache_resp !== 16'h0 || inv_addr !== 16'h0) begin
            mismatched++;
            $display("FAIL midflight_data: got mem_req=%h cache_resp=%h inv_addr=%h required 0",
                     mem_req, cache_resp, inv_addr);
        end
        cache_req_ready = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b1;
        prev_mrv = 0;
        tick();
        mem_resp       = 16'h2222;
        mem_resp_valid = 1'b1;
        repeat (3) tick();
        compared++;
        if (busy !== 1'b0 || cache_resp !== 16'h0) begin
            mismatched++;
            $display("FAIL midflight_late_resp: got busy=%b cache_resp=%h required busy=0 cache_resp=0000",
                     busy, cache_resp);
        end
        mem_enable = 1;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        logic [32:0] rq;
        do_reset();
        mem_enable = 0;
        rq = {WRITE, 16'h3333, 16'h0099};
        cache_req[0 +: 33] = rq;
        exp_mem.push_back(rq);
        e.rdy = 2'b01; e.data = 16'hDEAD; e.iaddr = 16'h0; e.ival = 2'b00; e.gnt = 3'd0;
        exp_resp.push_back(e);
        cache_req_ready = 2'b01;
        wait_drain("timeout", 60);
        compared++;
        if (timeout_err !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_err_set: got %b required 1", timeout_err);
        end
        mem_enable  = 1;
        mem_rd_data = 16'h4444;
        rq = {READ, 16'h0000, 16'h0055};
        cache_req[33 +: 33] = rq;
        expect_txn(1, rq, 16'h4444);
        cache_req_ready = 2'b10;
        wait_drain("after_timeout", 30);
        compared++;
        if (timeout_err !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_err_sticky: got %b required 1", timeout_err);
        end
    endtask
`endif

    initial begin
        reset           = 1'b0;
        cache_req       = '0;
        cache_req_ready = '0;
        mem_resp        = 16'h0;
        mem_resp_valid  = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_stray_resp();
        test_back_to_back();
        test_reset_midflight();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one main-memory port between NUM_CACHES cache instances using round-robin arbitration.
- Forwards the granted cache's 33-bit memory request ({rw, data[15:0], addr[15:0]}) to memory and routes the 16-bit response back to that cache only.
- On every granted write, broadcasts an invalidate of the written address to all other caches, keeping copies coherent.

Parameters:
- NUM_CACHES, 2, number of requesting caches (2..8).
- TIMEOUT_CYCLES, 255, memory watchdog limit. Used only with ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cache_req  in  33*NUM_CACHES  flattened per-cache memory_request; slice i = [33*i+32 : 33*i].
- cache_req_ready  in  NUM_CACHES  per-cache memory_request_ready; held high until the response.
- cache_resp  out  16  response data, broadcast to all caches.
- cache_resp_ready  out  NUM_CACHES  one-hot, one-cycle response strobe to the granted cache.
- inv_addr  out  16  address to invalidate, broadcast.
- inv_valid  out  NUM_CACHES  one-cycle invalidate strobe per cache.
- mem_req  out  33  request to main memory.
- mem_req_valid  out  1  one-cycle issue strobe.
- mem_resp  in  16  main-memory read data (ignored for writes).
- mem_resp_valid  in  1  one-cycle completion strobe; also used for write acknowledge.
- grant  out  3  index of the current owner (debug).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE; rr_ptr=0.
  - All outputs 0: cache_resp, cache_resp_ready, inv_addr, inv_valid, mem_req, mem_req_valid, grant, busy.
  - Takes effect mid-transaction; a late mem_resp_valid arriving after reset is ignored in IDLE.
- State register: 2 bits, one-hot-free encoding. States: IDLE, ISSUE, WAIT_MEM, RELEASE.
- IDLE:
  - If any cache_req_ready is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_CACHES.
  - Register grant, latch that cache's 33-bit request into req_q, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - mem_req=req_q; mem_req_valid=1.
  - Go to WAIT_MEM.
- WAIT_MEM:
  - mem_req holds req_q; mem_req_valid=0.
  - On mem_resp_valid:
    - cache_resp = (req_q[32]==0) ? mem_resp : req_q[31:16].
    - cache_resp_ready[grant]=1 for exactly one cycle.
    - If req_q[32]==1 (write): inv_addr=req_q[15:0] and inv_valid = all ones except bit grant, same cycle as the response strobe.
    - Go to RELEASE.
- RELEASE (1 cycle):
  - All strobes 0; rr_ptr = (grant+1) mod NUM_CACHES.
  - The granted cache's cache_req_ready is ignored this cycle, giving it time to drop. Then go to IDLE.
- Latency: request seen in IDLE -> mem_req_valid 2 cycles later. Response strobe appears the cycle after mem_resp_valid.
- Throughput: back-to-back requests are spaced by at least 4 cycles plus memory latency.
- Requester control:
  - Only grant's request is ever latched.
  - Changes on a granted cache's cache_req after latch are ignored.
  - A cache dropping cache_req_ready mid-transaction does not abort it; the response is still delivered.
- Simultaneous events: mem_resp_valid outside WAIT_MEM is dropped. Requests arriving during a transaction wait; no queueing beyond the ready level.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,N-1,0.
- inv_valid never has the writer's bit set.
- cache_resp holds its last value between strobes.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears in ISSUE and increments in WAIT_MEM.
  - When it reaches TIMEOUT_CYCLES without mem_resp_valid:
    - cache_resp=16'hDEAD and cache_resp_ready[grant] pulses.
    - No invalidate is issued, even for writes.
    - Sticky output port timeout_err (1 bit, reset 0) is set; cleared only by reset.
    - Go to RELEASE.
- Without the macro: no counter and no timeout_err port; WAIT_MEM waits indefinitely.

Decomposition:
- Package cache_pkg holds:
  - Request field constants: REQ_RW=32, REQ_DATA 31:16, REQ_ADDR 15:0.
  - READ=1'b0, WRITE=1'b1.
  - State encodings.
  - Request width 33.
- Sub-module rr_picker (combinational):
  - Inputs: req vector and rr_ptr.
  - Outputs: any, idx.
  - Reusable for future arbiters.

Test Plan:
- Cache0 read addr 16'h1234, memory returns 16'hABCD after 3 cycles -> mem_req={0,16'h0,16'h1234}, one-cycle mem_req_valid, cache_resp=16'hABCD with cache_resp_ready=2'b01, inv_valid=0.
- Cache1 write data 16'h5A5A to addr 16'h0042, memory acks -> cache_resp_ready=2'b10, inv_addr=16'h0042, inv_valid=2'b01 in the same cycle.
- Both caches request continuously for 6 transactions -> grant sequence 0,1,0,1,0,1; never the same cache twice in a row.
- Reset driven low during WAIT_MEM, then mem_resp_valid arrives after reset release -> all outputs 0, no cache_resp_ready pulse, state IDLE.
- Stray mem_resp_valid in IDLE -> no strobes, grant unchanged.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, memory never responds -> cache_resp=16'hDEAD pulses to the requester, timeout_err=1, arbiter returns to IDLE and serves the next request.
